// File: rtl/gameconsole_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gameconsole_pkg : shared screen timing defaults and pixel types       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package gameconsole_pkg;

   localparam int DEF_SCREEN_W      = 320;
   localparam int DEF_SCREEN_H      = 240;
   localparam int DEF_SCREEN_HBLANK = 80;
   localparam int DEF_SCREEN_VBLANK = 22;
   localparam int DEF_CYC_PER_PIX   = 4;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } argb_t;

   // Fully transparent pixels show the background colour; anything else is opaque.
   function automatic logic [23:0] argb_to_rgb(input argb_t px, input logic [23:0] bg);
      return (px.a == 8'h00) ? bg : {px.r, px.g, px.b};
   endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_linebuf_dp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vpu_linebuf_dp : one-write/one-read line buffer with registered read  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module vpu_linebuf_dp
   import gameconsole_pkg::*;
#(
   parameter int DEPTH = DEF_SCREEN_W
)(
   input  logic       clk,
   input  logic       we,
   input  logic [8:0] waddr,
   input  argb_t      wdata,
   input  logic       re,
   input  logic [8:0] raddr,
   output argb_t      rdata
);

   argb_t r_mem [DEPTH];

   // Contents are deliberately not reset: a frame can be redisplayed after reset.
   always_ff @(posedge clk) begin
      if (we)
         r_mem[waddr] <= wdata;
      if (re)
         rdata <= r_mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/vpu_line_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vpu_line_scanout : double-buffered line scanout with raster timing    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module vpu_line_scanout
   import gameconsole_pkg::*;
#(
   parameter int SCREEN_W      = DEF_SCREEN_W,
   parameter int SCREEN_H      = DEF_SCREEN_H,
   parameter int SCREEN_HBLANK = DEF_SCREEN_HBLANK,
   parameter int SCREEN_VBLANK = DEF_SCREEN_VBLANK,
   parameter int CYC_PER_PIX   = DEF_CYC_PER_PIX
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [8:0]  wr_x,
   input  logic [31:0] wr_data,
   input  logic        wr_line_done,
   input  logic [23:0] bg_color,
   output logic        line_req,
   output logic [8:0]  req_y,
   output logic        pix_valid,
   output logic [23:0] pix_rgb,
   output logic        hsync,
   output logic        vsync,
   output logic [15:0] underrun_cnt
);

   localparam int HTOT  = SCREEN_W + SCREEN_HBLANK;
   localparam int VTOT  = SCREEN_H + SCREEN_VBLANK;
   localparam int DIV_W = (CYC_PER_PIX > 1) ? $clog2(CYC_PER_PIX) : 1;

   localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CYC_PER_PIX - 1);
   localparam logic [9:0]       c_HLAST    = 10'(HTOT - 1);
   localparam logic [9:0]       c_W10      = 10'(SCREEN_W);
   localparam logic [8:0]       c_W9       = 9'(SCREEN_W);
   localparam logic [8:0]       c_VLAST    = 9'(VTOT - 1);
   localparam logic [8:0]       c_H9       = 9'(SCREEN_H);

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_hcount;
   logic [8:0]       r_vcount;
   logic             r_front;
   logic             r_back_ready;
   logic [15:0]      r_underrun;
   logic             r_pix_valid;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_rd_sel;

   logic  w_tick, w_hwrap, w_vlast, w_h_vis, w_v_vis, w_rd_en, w_wr_ok;
   argb_t w_rdata [2];

   assign w_tick  = (r_div == c_DIV_LAST);
   assign w_hwrap = w_tick && (r_hcount == c_HLAST);
   assign w_vlast = (r_vcount == c_VLAST);
   assign w_h_vis = (r_hcount < c_W10);
   assign w_v_vis = (r_vcount < c_H9);
   assign w_rd_en = (r_div == '0) && w_h_vis && w_v_vis;
   assign w_wr_ok = wr_en && (wr_x < c_W9);

   // Buffer b is the back buffer whenever it is not selected as front.
   for (genvar b = 0; b < 2; b++) begin : g_buf
      vpu_linebuf_dp #(.DEPTH(SCREEN_W)) u_ram (
         .clk   (clk),
         .we    (w_wr_ok && (r_front != 1'(b))),
         .waddr (wr_x),
         .wdata (argb_t'(wr_data)),
         .re    (w_rd_en),
         .raddr (r_hcount[8:0]),
         .rdata (w_rdata[b])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div        <= '0;
         r_hcount     <= '0;
         r_vcount     <= '0;
         r_front      <= 1'b0;
         r_back_ready <= 1'b0;
         r_underrun   <= '0;
         r_pix_valid  <= 1'b0;
         r_hsync      <= 1'b0;
         r_vsync      <= 1'b0;
         r_rd_sel     <= 1'b0;
      end else begin
         r_div <= w_tick ? '0 : r_div + DIV_W'(1);
         if (w_tick)
            r_hcount <= (r_hcount == c_HLAST) ? '0 : r_hcount + 10'd1;
         if (w_hwrap)
            r_vcount <= w_vlast ? '0 : r_vcount + 9'd1;

         // A done pulse landing on the swap point still counts as ready.
         if (w_hwrap) begin
            if (r_back_ready || wr_line_done) begin
               r_front      <= ~r_front;
               r_back_ready <= 1'b0;
            end else if (r_underrun != 16'hFFFF) begin
               r_underrun <= r_underrun + 16'd1;
            end
         end else if (wr_line_done) begin
            r_back_ready <= 1'b1;
         end

         r_pix_valid <= w_rd_en;
         r_hsync     <= w_h_vis;
         r_vsync     <= w_v_vis;
         if (w_rd_en)
            r_rd_sel <= r_front;
      end
   end

   // line_req/req_y must be valid on the very first clock after reset release.
   assign line_req     = !rst && (r_div == '0) && (r_hcount == '0);
   assign req_y        = rst ? '0 : (w_vlast ? '0 : r_vcount + 9'd1);
   assign pix_valid    = r_pix_valid;
   assign pix_rgb      = r_pix_valid ? argb_to_rgb(w_rdata[r_rd_sel], bg_color) : 24'h0;
   assign hsync        = r_hsync;
   assign vsync        = r_vsync;
   assign underrun_cnt = r_underrun;

endmodule
`default_nettype wire

// File: doc/vpu_line_scanout.md
VPU_LINE_SCANOUT -- requirements
Module: vpu_line_scanout

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  SCREEN_W, 320, visible pixels per line.
  SCREEN_H, 240, visible lines per frame.
  SCREEN_HBLANK, 80, blank pixels per line.
  SCREEN_VBLANK, 22, blank lines per frame.
  CYC_PER_PIX, 4, clocks per pixel.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  sole clock.
  rst  in  1  reset; one clock; reset is synchronous and active-high.
  wr_en  in  1  line-buffer write strobe from the sprite/BG renderer.
  wr_x  in  9  write pixel index.
  wr_data  in  32  ARGB8888 pixel.
  wr_line_done  in  1  pulse: back buffer complete.
  bg_color  in  24  RGB used for alpha==0 pixels.
  line_req  out  1  pulse: start rendering line req_y.
  req_y  out  9  line the renderer fills next.
  pix_valid  out  1  strobe: pix_rgb holds a visible pixel.
  pix_rgb  out  24  output RGB888.
  hsync  out  1  high while hcount is visible.
  vsync  out  1  high while vcount is visible.
  underrun_cnt  out  16  saturating count of missed swaps.

Function
REQ-003 The block SHALL hold two SCREEN_W x 32 line buffers: front (read) and back (write), with a 1-bit front-select register.
REQ-004 Writes with wr_en=1 SHALL update back[wr_x] on the next edge; writes with wr_x >= SCREEN_W SHALL be ignored.
REQ-005 wr_line_done SHALL set back_ready=1; writes after back_ready=1 and before a swap SHALL still land in back.
REQ-006 div SHALL count 0..CYC_PER_PIX-1 and wrap; the pixel tick is div==CYC_PER_PIX-1.
REQ-007 hcount SHALL advance on each tick, 0..SCREEN_W+SCREEN_HBLANK-1, and wrap; vcount SHALL advance when hcount wraps, 0..SCREEN_H+SCREEN_VBLANK-1, and wrap.
REQ-008 The read of front[hcount] SHALL be issued at div==0 of each visible pixel.
REQ-009 pix_rgb, pix_valid, hsync and vsync SHALL be registered and asserted one clock after the read, so latency is 1 clock from div==0.
REQ-010 pix_valid SHALL be a 1-clock strobe per visible pixel.
REQ-011 If the pixel alpha is 0, pix_rgb SHALL be bg_color; otherwise it SHALL be data[23:0], with no blending.
REQ-012 line_req SHALL pulse for 1 clock at hcount==0, div==0.
REQ-013 req_y SHALL equal vcount+1, wrapping to 0 after the last vcount.
REQ-014 Swap: on the clock where hcount wraps, if back_ready=1 the block SHALL toggle front-select and clear back_ready.
REQ-015 If back_ready=0 at a swap point, the front buffer SHALL be retained (the line repeats) and underrun_cnt SHALL increment, saturating at 16'hFFFF.
REQ-016 Swap points during vertical blank SHALL be evaluated identically; underruns during blank SHALL be counted.
REQ-017 If wr_line_done and a swap point coincide, the swap SHALL occur and back_ready SHALL end at 0.
REQ-018 A write and a swap in the same clock SHALL target the pre-swap back buffer.

Reset
REQ-019 While rst=1, the block SHALL hold div, hcount, vcount, front-select, back_ready, underrun_cnt and every output at 0.
REQ-020 Buffer contents SHALL NOT be cleared by reset.
REQ-021 Reset asserted mid-line SHALL abort the line; the first clock after release SHALL be div=0, hcount=0, vcount=0, with line_req=1 on that clock.

Structure
REQ-022 The SCREEN_* and CYC_PER_PIX defaults and an ARGB pixel typedef SHALL live in gameconsole_pkg.
REQ-023 One sub-module, vpu_linebuf_dp (1W/1R, registered read, 9-bit address), SHALL be instantiated twice.

Verification
REQ-024 Reset release: the bench SHALL see line_req at clock 0 with req_y=1, and the first pix_valid at clock 1 with hsync=1 and vsync=1.
REQ-025 Fill back with x=i and ARGB=FF0000i0, then pulse wr_line_done: after the next hcount wrap, pix_rgb SHALL be 0000i0 for i=0..319.
REQ-026 No wr_line_done for 3 lines: underrun_cnt SHALL be 3 and each line SHALL repeat the prior pixels.
REQ-027 wr_data=00123456 with bg_color=ABCDEF: pix_rgb SHALL be ABCDEF.
REQ-028 wr_line_done on the same clock as the hcount wrap: a swap SHALL occur and underrun_cnt SHALL stay unchanged.
REQ-029 wr_x=320 with wr_data=FFFFFFFF: no buffer word SHALL change.
